// File: rtl/frame_pkg.sv
// Shared types, CRC constants and the byte-wise CRC-32 step for the frame
// signature block.
package frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic [31:0] CRC32_POLY = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

  // Reflected CRC-32: fold one byte in LSB first.
  function automatic logic [31:0] crc32_update(input logic [31:0] crc,
                                               input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/frame_edge_det.sv
// Registered rising-edge detector. The armed flag keeps a level that was
// already high when reset released from looking like a fresh edge; the input
// has to be seen low once before any pulse can fire.
module frame_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic pulse_o
);

  logic sig_q;
  logic armed_q;
  logic pulse_q;

  // Sample the input and register the one-cycle rising-edge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q   <= 1'b0;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register reads the pre-edge value of its
      // neighbours; blocking here would let pulse_q see the new sig_q.
      sig_q   <= sig_i;
      armed_q <= armed_q | ~sig_i;
      pulse_q <= sig_i & ~sig_q & armed_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/frame_signature.sv
// Captures a CRC-32 signature and pixel count for selected frames of a video
// stream and publishes them through a valid/ready handshake.
module frame_signature
  import frame_pkg::*;
#(
  parameter int unsigned IMAGE_W     = 256,
  parameter int unsigned IMAGE_H     = 240,
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned START_FRAME = 1,
  parameter int unsigned STOP_FRAME  = 3,
  parameter int unsigned DECIMATE    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pixel,
  input  logic             pixel_en,
  input  logic             frame,
  output logic             record_en,
  output logic             sig_valid,
  input  logic             sig_ready,
  output logic [31:0]      sig_crc,
  output logic [15:0]      sig_frame,
  output logic             sig_count_err,
  output logic             overflow,
  output logic             done
);

  localparam logic [19:0] FRAME_PIXELS = 20'(IMAGE_W * IMAGE_H);

  function automatic logic is_eligible(input logic [15:0] n);
    int unsigned nn;
    nn = 32'(n);
    return (nn >= START_FRAME) && (nn <= STOP_FRAME) &&
           (((nn - START_FRAME) % DECIMATE) == 0);
  endfunction

  logic        start_pulse;
  state_e      state_q,     state_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] crc_q,       crc_d;
  logic [19:0] pix_cnt_q,   pix_cnt_d;
  logic        sig_valid_q, sig_valid_d;
  logic [31:0] sig_crc_q,   sig_crc_d;
  logic [15:0] sig_frame_q, sig_frame_d;
  logic        sig_err_q,   sig_err_d;
  logic        overflow_q,  overflow_d;

  logic        accept;
  logic [7:0]  pix8;
  logic [31:0] crc_upd;
  logic [19:0] cnt_upd;
  logic [15:0] next_frame;

  frame_edge_det u_edge (
    .clk     (clk),
    .rst     (rst),
    .sig_i   (frame),
    .pulse_o (start_pulse)
  );

  // State, accumulators and the published signature.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      crc_q       <= CRC32_INIT;
      pix_cnt_q   <= '0;
      sig_valid_q <= 1'b0;
      sig_crc_q   <= '0;
      sig_frame_q <= '0;
      sig_err_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      crc_q       <= crc_d;
      pix_cnt_q   <= pix_cnt_d;
      sig_valid_q <= sig_valid_d;
      sig_crc_q   <= sig_crc_d;
      sig_frame_q <= sig_frame_d;
      sig_err_q   <= sig_err_d;
      overflow_q  <= overflow_d;
    end
  end

  // Next state: accumulate pixels, close/open frames on the start pulse,
  // and run the signature handshake.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves one unassigned, which would infer a latch.
    pix8          = '0;
    pix8[PIX_W-1:0] = pixel;
    accept        = (state_q == ST_CAPTURE) && pixel_en;
    crc_upd       = accept ? crc32_update(crc_q, pix8) : crc_q;
    cnt_upd       = (accept && (pix_cnt_q != '1)) ? pix_cnt_q + 20'd1 : pix_cnt_q;
    next_frame    = frame_cnt_q + 16'd1;

    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    crc_d         = crc_upd;
    pix_cnt_d     = cnt_upd;
    sig_valid_d   = sig_valid_q & ~sig_ready;
    sig_crc_d     = sig_crc_q;
    sig_frame_d   = sig_frame_q;
    sig_err_d     = sig_err_q;
    overflow_d    = overflow_q;

    if (start_pulse && (state_q != ST_DONE)) begin
      frame_cnt_d = next_frame;
      crc_d       = CRC32_INIT;
      pix_cnt_d   = '0;
      state_d     = is_eligible(next_frame) ? ST_CAPTURE : ST_SKIP;
      if (state_q == ST_CAPTURE) begin
        // The pixel arriving with the pulse still belongs to the closing frame.
        if (frame_cnt_q == 16'(STOP_FRAME)) state_d = ST_DONE;
        if (sig_valid_q && !sig_ready) begin
          overflow_d = 1'b1;
        end else begin
          sig_valid_d = 1'b1;
          sig_crc_d   = ~crc_upd;
          sig_frame_d = frame_cnt_q;
          sig_err_d   = (cnt_upd != FRAME_PIXELS);
        end
      end
    end
  end

  assign record_en     = (state_q == ST_CAPTURE);
  assign done          = (state_q == ST_DONE);
  assign sig_valid     = sig_valid_q;
  assign sig_crc       = sig_crc_q;
  assign sig_frame     = sig_frame_q;
  assign sig_count_err = sig_err_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_frame_signature.sv
// Self-checking bench for frame_signature: a 3x3 image capturing frames
// 2, 4 and 6; signatures are predicted into a queue and compared on transfer.
module tb_frame_signature;

  localparam int W = 3, H = 3, START = 2, STOP = 6, DEC = 2;

  logic        clk, rst;
  logic [7:0]  pixel;
  logic        pixel_en, frame, sig_ready;
  logic        record_en, sig_valid, sig_count_err, overflow, done;
  logic [31:0] sig_crc;
  logic [15:0] sig_frame;

  frame_signature #(
    .IMAGE_W(W), .IMAGE_H(H), .PIX_W(8),
    .START_FRAME(START), .STOP_FRAME(STOP), .DECIMATE(DEC)
  ) dut (
    .clk(clk), .rst(rst), .pixel(pixel), .pixel_en(pixel_en), .frame(frame),
    .record_en(record_en), .sig_valid(sig_valid), .sig_ready(sig_ready),
    .sig_crc(sig_crc), .sig_frame(sig_frame), .sig_count_err(sig_count_err),
    .overflow(overflow), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] crc;
    logic [15:0] frm;
    logic        err;
  } sig_t;

  typedef struct {
    logic        elig;
    int          npix;
    logic [7:0]  base;
    logic [31:0] crc;
  } vec_t;

  sig_t exp_q[$];
  vec_t vec[7];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_xfer  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference CRC-32 over n consecutive bytes starting at base.
  function automatic logic [31:0] crc_ref(input int n, input logic [7:0] base);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      b = 8'(base + i);
      for (int k = 0; k < 8; k++) begin
        if ((c[0] ^ b[k]) == 1'b1) c = (c >> 1) ^ 32'hEDB8_8320;
        else                       c = c >> 1;
      end
    end
    return ~c;
  endfunction

  // Scoreboard: every transfer must match the oldest predicted signature.
  always @(negedge clk) begin
    if (!rst && sig_valid && sig_ready) begin
      n_xfer++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_sig: frame %0d crc %h", sig_frame, sig_crc);
      end else begin
        sig_t e;
        e = exp_q.pop_front();
        check("sig_crc",       sig_crc,       e.crc);
        check("sig_frame",     32'(sig_frame), 32'(e.frm));
        check("sig_count_err", 32'(sig_count_err), 32'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Rising frame edge; returns at the start of cycle C+1.
  task automatic frame_edge(input logic pix_in_c, input logic [7:0] pv);
    frame = 1'b1;
    step();
    frame    = 1'b0;
    pixel_en = pix_in_c;
    pixel    = pv;
    step();
    pixel_en = 1'b0;
  endtask

  task automatic send_pix(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      pixel    = 8'(base + i);
      pixel_en = 1'b1;
      step();
    end
    pixel_en = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      step();
      k++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_record_en"}, 32'(record_en),     32'd0);
    check({tag, "_sig_valid"}, 32'(sig_valid),     32'd0);
    check({tag, "_sig_crc"},   sig_crc,            32'd0);
    check({tag, "_sig_frame"}, 32'(sig_frame),     32'd0);
    check({tag, "_count_err"}, 32'(sig_count_err), 32'd0);
    check({tag, "_overflow"},  32'(overflow),      32'd0);
    check({tag, "_done"},      32'(done),          32'd0);
  endtask

  initial begin
    int x0;
    rst = 1'b1; frame = 1'b0; pixel_en = 1'b0; pixel = '0; sig_ready = 1'b1;
    step(); step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Frames 1..7: eligibility, pixel count and data pattern per frame.
    vec[0] = '{1'b0, 3,  8'h55, 32'h0};
    vec[1] = '{1'b1, 9,  8'h31, 32'hCBF4_3926};
    vec[2] = '{1'b0, 3,  8'h55, 32'h0};
    vec[3] = '{1'b1, 8,  8'h31, crc_ref(8, 8'h31)};
    vec[4] = '{1'b0, 3,  8'h55, 32'h0};
    vec[5] = '{1'b1, 10, 8'hA0, crc_ref(10, 8'hA0)};
    vec[6] = '{1'b0, 3,  8'h55, 32'h0};

    for (int f = 0; f < 7; f++) begin
      if (f > 0 && vec[f-1].elig)
        exp_q.push_back('{vec[f-1].crc, 16'(f), (vec[f-1].npix != W * H)});
      frame_edge(1'b0, 8'h00);
      check($sformatf("record_en_f%0d", f + 1), 32'(record_en), 32'(vec[f].elig));
      send_pix(vec[f].npix, vec[f].base);
    end
    check("done_after_stop", 32'(done), 32'd1);
    wait_drain("main_drain");
    check("main_xfers", 32'(n_xfer), 32'd3);

    // Frame activity after DONE is ignored.
    frame_edge(1'b0, 8'h00);
    send_pix(9, 8'h31);
    frame_edge(1'b0, 8'h00);
    step(); step();
    check("done_hold",        32'(done),      32'd1);
    check("done_record_en",   32'(record_en), 32'd0);
    check("done_sig_valid",   32'(sig_valid), 32'd0);
    check("done_no_xfer",     32'(n_xfer),    32'd3);

    // Back-pressure across two publishes: second is dropped.
    do_reset();
    sig_ready = 1'b0;
    frame_edge(1'b0, 8'h00);
    frame_edge(1'b0, 8'h00);
    send_pix(9, 8'h31);
    frame_edge(1'b0, 8'h00);
    send_pix(3, 8'h41);
    frame_edge(1'b0, 8'h00);
    send_pix(9, 8'h61);
    frame_edge(1'b0, 8'h00);
    step();
    check("ovf_valid_held", 32'(sig_valid),  32'd1);
    check("ovf_frame_held", 32'(sig_frame),  32'd2);
    check("ovf_crc_held",   sig_crc,         32'hCBF4_3926);
    check("ovf_flag",       32'(overflow),   32'd1);
    exp_q.push_back('{32'hCBF4_3926, 16'd2, 1'b0});
    x0 = n_xfer;
    sig_ready = 1'b1;
    step();
    check("ovf_one_xfer",   32'(n_xfer - x0), 32'd1);
    check("ovf_valid_drop", 32'(sig_valid),   32'd0);
    check("ovf_sticky",     32'(overflow),    32'd1);

    // Reset mid-capture with pixels flowing and frame held high through release.
    do_reset();
    frame_edge(1'b0, 8'h00);
    frame_edge(1'b0, 8'h00);
    pixel = 8'h77;
    pixel_en = 1'b1;
    step(); step();
    frame = 1'b1;
    rst = 1'b1;
    step(); step();
    check_reset_outputs("midrst");
    rst = 1'b0;
    step(); step(); step();
    check("held_frame_no_capture", 32'(record_en), 32'd0);
    frame = 1'b0;
    pixel_en = 1'b0;
    step(); step();
    frame_edge(1'b0, 8'h00);
    check("post_rst_f1_skip", 32'(record_en), 32'd0);
    frame_edge(1'b0, 8'h00);
    check("post_rst_f2_cap",  32'(record_en), 32'd1);

    // Pixel in the pulse cycle C belongs to the closing frame only.
    send_pix(8, 8'h31);
    exp_q.push_back('{32'hCBF4_3926, 16'd2, 1'b0});
    frame_edge(1'b1, 8'h39);
    check("c_pixel_f3_skip", 32'(record_en), 32'd0);
    send_pix(3, 8'h55);
    frame_edge(1'b1, 8'hFF);
    check("c_pixel_f4_cap",  32'(record_en), 32'd1);
    send_pix(9, 8'h31);
    exp_q.push_back('{32'hCBF4_3926, 16'd4, 1'b0});
    frame_edge(1'b0, 8'h00);
    wait_drain("c_pixel_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_signature.md
FRAME_SIGNATURE -- requirements
Module: frame_signature

Interface
REQ-001 Parameter IMAGE_W, default 256, active pixels per line.
REQ-002 Parameter IMAGE_H, default 240, active lines per frame.
REQ-003 Parameter PIX_W, default 8, pixel width in bits (1..8).
REQ-004 Parameter START_FRAME, default 1, first frame number eligible for capture.
REQ-005 Parameter STOP_FRAME, default 3, last frame number captured; must be >= START_FRAME.
REQ-006 Parameter DECIMATE, default 1, capture every DECIMATE-th eligible frame (>= 1).
REQ-007 clk  input  1  clock.
REQ-008 rst  input  1  reset: rst, synchronous, active-high.
REQ-009 pixel  input  PIX_W  pixel value.
REQ-010 pixel_en  input  1  pixel qualifier.
REQ-011 frame  input  1  frame marker; each rising edge starts a new frame.
REQ-012 record_en  output  1  high while the current frame is being captured.
REQ-013 sig_valid  output  1  signature available.
REQ-014 sig_ready  input  1  consumer accepts the signature.
REQ-015 sig_crc  output  32  CRC-32 of the captured frame.
REQ-016 sig_frame  output  16  number of the captured frame.
REQ-017 sig_count_err  output  1  captured pixel count was not IMAGE_W*IMAGE_H.
REQ-018 overflow  output  1  sticky; a signature was dropped.
REQ-019 done  output  1  STOP_FRAME signature published; block idle.

Function
REQ-020 Edge detect: frame is registered; start pulse = frame & ~frame_q, registered; the pulse is active in cycle C, one cycle after frame is first sampled high.
REQ-021 Frame counter (16-bit) increments on each start pulse; first pulse gives frame 1; it wraps at 2^16 without error.
REQ-022 Frame n is eligible when n >= START_FRAME, n <= STOP_FRAME and (n - START_FRAME) mod DECIMATE == 0.
REQ-023 States: IDLE (before first pulse), SKIP (ineligible frame), CAPTURE, DONE.
REQ-024 On a start pulse: the frame being closed (if CAPTURE) is published; the next state is CAPTURE if the new frame is eligible, else SKIP.
REQ-025 A pixel_en in cycle C belongs to the closing frame; the first pixel of the new frame is in cycle C+1.
REQ-026 record_en = (state == CAPTURE); it rises in cycle C+1.
REQ-027 CRC: reflected CRC-32 (poly 0xEDB88320), init 0xFFFFFFFF, final XOR 0xFFFFFFFF; one byte per accepted pixel, pixel zero-extended to 8 bits.
REQ-028 Pixel counter is 20-bit and saturates at its maximum value.
REQ-029 sig_count_err = (count != IMAGE_W*IMAGE_H).
REQ-030 Publish: sig_valid rises in cycle C+1; sig_crc, sig_frame and sig_count_err are stable while sig_valid is high.
REQ-031 Handshake: the signature is consumed at a clock edge where sig_valid & sig_ready; sig_valid drops the next cycle unless a new publish occurs in that same cycle.
REQ-032 Publish while sig_valid is high and not consumed in that cycle: the new signature is dropped, overflow is set, and the old signature is held.
REQ-033 Publishing frame STOP_FRAME moves the state to DONE; done=1; further frame edges and pixels are ignored until reset; the pending signature still completes its handshake.
REQ-034 A frame that is still open when sim/reset intervenes is never published.

Reset
REQ-035 rst discards any in-progress capture; record_en, sig_valid, sig_count_err, overflow and done = 0; sig_crc = 0; sig_frame = 0; frame counter = 0; state = IDLE; frame_q = 0.
REQ-036 A frame held high through reset release produces no start pulse until it falls and rises again.

Structure
REQ-037 A shared package frame_pkg holds the state enum, the CRC32_POLY/CRC32_INIT constants, and a byte-wise crc32_update function.
REQ-038 One sub-module, frame_edge_det (register plus rising-edge pulse), is instantiated for frame.

Verification
REQ-039 IMAGE_W=3, IMAGE_H=3, START=1, STOP=1, pixels 0x31..0x39, sig_ready=1 -> sig_crc=0xCBF43926, sig_frame=1, sig_count_err=0, done=1.
REQ-040 Same config, only 8 pixels sent -> sig_count_err=1; 10 pixels sent -> sig_count_err=1.
REQ-041 START=2, STOP=6, DECIMATE=2, 7 frame edges -> record_en only in frames 2, 4 and 6; exactly 3 signatures with sig_frame=2, 4, 6.
REQ-042 sig_ready=0 across two publishes -> first signature held, overflow=1; sig_ready=1 -> one transfer, then sig_valid=0.
REQ-043 rst asserted mid-CAPTURE with pixels flowing -> all outputs reset and no signature; the next frame edge gives frame 1.
REQ-044 pixel_en asserted in the start-pulse cycle C -> that pixel is counted in the closing frame's CRC, not in the new frame.
